// File: rtl/pulse_dispatcher_if.sv
// rtl/pulse_dispatcher_if.sv - FIFO read, timebase and pulse-output signals of the pulse dispatcher
interface pulse_dispatcher_if #(
    parameter int TIME_W = 32,
    parameter int DUR_W  = 16,
    parameter int CH_W   = 3,
    parameter int WAVE_W = 8,
    parameter int DESC_W = TIME_W + DUR_W + CH_W + WAVE_W
);
    logic [DESC_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              time_run;
    logic              time_clr;
    logic [TIME_W-1:0] time_now;
    logic              pulse_start;
    logic              pulse_busy;
    logic [CH_W-1:0]   pulse_channel;
    logic [WAVE_W-1:0] pulse_wave_id;
    logic              late_flag;
    logic [7:0]        late_count;
    logic              late_clr;

    modport master (
        input  fifo_rd_data, fifo_empty, time_run, time_clr, late_clr,
        output fifo_rd_en, time_now, pulse_start, pulse_busy,
               pulse_channel, pulse_wave_id, late_flag, late_count
    );

    modport slave (
        output fifo_rd_data, fifo_empty, time_run, time_clr, late_clr,
        input  fifo_rd_en, time_now, pulse_start, pulse_busy,
               pulse_channel, pulse_wave_id, late_flag, late_count
    );
endinterface

// File: rtl/pulse_dispatcher.sv
// rtl/pulse_dispatcher.sv - pops pulse descriptors and plays each at its start time on a local timebase
module pulse_dispatcher #(
    parameter int TIME_W = 32,
    parameter int DUR_W  = 16,
    parameter int CH_W   = 3,
    parameter int WAVE_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    pulse_dispatcher_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLAY} state_t;

    state_t            state_q;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] start_q;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  remain_q;
    logic [CH_W-1:0]   ch_q;
    logic [WAVE_W-1:0] wave_q;
    logic              first_q;
    logic              pulse_start_q;
    logic              pulse_busy_q;
    logic [CH_W-1:0]   pulse_ch_q;
    logic [WAVE_W-1:0] pulse_wave_q;
    logic              late_flag_q;
    logic [7:0]        late_cnt_q;

    logic [TIME_W-1:0] time_d;
    logic [TIME_W-1:0] diff;
    logic              due;
    logic              late_evt;
    logic [DUR_W-1:0]  play_len;
    logic [7:0]        late_base;
    logic [7:0]        late_cnt_d;
    logic              late_flag_d;
    logic              pop;

    // Popping during reset would silently lose the head descriptor.
    assign pop      = rst_n && (state_q == S_IDLE) && !bus.fifo_empty;
    assign time_d   = bus.time_clr ? '0 : (bus.time_run ? time_q + 1'b1 : time_q);
    assign diff     = time_q - start_q;
    assign due      = !diff[TIME_W-1];
    assign late_evt = (state_q == S_WAIT) && first_q && due && (diff != '0);
    assign play_len = (dur_q == '0) ? DUR_W'(1) : dur_q;

    // Clear is applied before the same-cycle late event is counted.
    assign late_base   = bus.late_clr ? 8'd0 : late_cnt_q;
    assign late_cnt_d  = (late_evt && late_base != 8'hFF) ? late_base + 8'd1 : late_base;
    assign late_flag_d = (bus.late_clr ? 1'b0 : late_flag_q) | late_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            time_q        <= '0;
            start_q       <= '0;
            dur_q         <= '0;
            remain_q      <= '0;
            ch_q          <= '0;
            wave_q        <= '0;
            first_q       <= 1'b0;
            pulse_start_q <= 1'b0;
            pulse_busy_q  <= 1'b0;
            pulse_ch_q    <= '0;
            pulse_wave_q  <= '0;
            late_flag_q   <= 1'b0;
            late_cnt_q    <= 8'd0;
        end else begin
            time_q      <= time_d;
            late_cnt_q  <= late_cnt_d;
            late_flag_q <= late_flag_d;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {start_q, dur_q, ch_q, wave_q} <= bus.fifo_rd_data;
                        first_q <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    first_q <= 1'b0;
                    if (due) begin
                        state_q       <= S_PLAY;
                        remain_q      <= play_len;
                        pulse_start_q <= 1'b1;
                        pulse_busy_q  <= 1'b1;
                        pulse_ch_q    <= ch_q;
                        pulse_wave_q  <= wave_q;
                    end
                end
                S_PLAY: begin
                    pulse_start_q <= 1'b0;
                    if (remain_q == DUR_W'(1)) begin
                        state_q      <= S_IDLE;
                        pulse_busy_q <= 1'b0;
                        pulse_ch_q   <= '0;
                        pulse_wave_q <= '0;
                    end else begin
                        remain_q <= remain_q - DUR_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en    = pop;
    assign bus.time_now      = time_q;
    assign bus.pulse_start   = pulse_start_q;
    assign bus.pulse_busy    = pulse_busy_q;
    assign bus.pulse_channel = pulse_ch_q;
    assign bus.pulse_wave_id = pulse_wave_q;
    assign bus.late_flag     = late_flag_q;
    assign bus.late_count    = late_cnt_q;
endmodule

// File: tb/tb_pulse_dispatcher.sv
// tb/tb_pulse_dispatcher.sv - directed and randomized bench for pulse_dispatcher with a schedule model
module tb_pulse_dispatcher;
    localparam int TW    = 8;
    localparam int DW    = 16;
    localparam int CW    = 3;
    localparam int WW    = 8;
    localparam int DESCW = TW + DW + CW + WW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_dispatcher_if #(.TIME_W(TW), .DUR_W(DW), .CH_W(CW), .WAVE_W(WW)) bus ();

    pulse_dispatcher #(.TIME_W(TW), .DUR_W(DW), .CH_W(CW), .WAVE_W(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DESCW-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = mem[rd_ptr % 1024];

    always @(posedge clk) begin
        if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    logic [TW-1:0] tm;
    int  lc;
    bit  lf;
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [TW-1:0] st, input int dur, input int ch, input int wv);
        mem[wr_ptr % 1024] = {st, DW'(dur), CW'(ch), WW'(wv)};
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n || bus.time_clr) tm = '0;
        else if (bus.time_run) tm = tm + 1'b1;
        @(negedge clk);
    endtask

    // Plays out everything currently queued; called at a negedge with the DUT idle and time running.
    task automatic run_batch(input int clr_idx);
        int nd, c, total, di;
        int pop_c [64];
        int ws [64];
        int ns [64];
        int chs [64];
        int wvs [64];
        logic [DESCW-1:0] desc;
        logic [TW-1:0] st, t1, tm0;
        logic signed [TW-1:0] d;
        int dur;
        bit e_rd, e_busy, e_start;
        int e_ch, e_wv;
        nd = wr_ptr - rd_ptr;
        tm0 = tm;
        c = 0;
        for (int j = 0; j < nd; j++) begin
            desc = mem[(rd_ptr + j) % 1024];
            st = desc[DESCW-1 -: TW];
            dur = int'(desc[WW+CW +: DW]);
            chs[j] = int'(desc[WW +: CW]);
            wvs[j] = int'(desc[0 +: WW]);
            pop_c[j] = c;
            t1 = tm0 + TW'(c + 1);
            d = t1 - st;
            di = d;
            ws[j] = (di >= 0) ? 1 : 1 - di;
            ns[j] = (dur == 0) ? 1 : dur;
            if (j == clr_idx) begin lc = 0; lf = 0; end
            if (di > 0) begin lf = 1; lc = (lc < 255) ? lc + 1 : 255; end
            c = c + ws[j] + ns[j] + 1;
        end
        total = c;
        for (int cc = 0; cc <= total; cc++) begin
            bus.late_clr = (clr_idx >= 0) && (cc == pop_c[clr_idx] + 1);
            #1;
            e_rd = 0; e_busy = 0; e_start = 0; e_ch = 0; e_wv = 0;
            for (int j = 0; j < nd; j++) begin
                if (cc == pop_c[j]) e_rd = 1;
                if (cc >= pop_c[j] + ws[j] + 1 && cc <= pop_c[j] + ws[j] + ns[j]) begin
                    e_busy = 1;
                    e_start = (cc == pop_c[j] + ws[j] + 1);
                    e_ch = chs[j];
                    e_wv = wvs[j];
                end
            end
            chk($sformatf("rd_en@%0d", cc), 32'(bus.fifo_rd_en), 32'(e_rd));
            chk($sformatf("busy@%0d", cc), 32'(bus.pulse_busy), 32'(e_busy));
            chk($sformatf("start@%0d", cc), 32'(bus.pulse_start), 32'(e_start));
            chk($sformatf("channel@%0d", cc), 32'(bus.pulse_channel), 32'(e_ch));
            chk($sformatf("wave@%0d", cc), 32'(bus.pulse_wave_id), 32'(e_wv));
            chk($sformatf("time@%0d", cc), 32'(bus.time_now), 32'(tm));
            if (cc < total) tick();
        end
        bus.late_clr = 1'b0;
        chk("late_flag", 32'(bus.late_flag), 32'(lf));
        chk("late_count", 32'(bus.late_count), 32'(lc));
        chk("all_popped", 32'(rd_ptr), 32'(wr_ptr));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.time_run = 1'b0;
        bus.time_clr = 1'b0;
        bus.late_clr = 1'b0;
        tm = '0; lc = 0; lf = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_time", 32'(bus.time_now), 32'd0);
        chk("rst_busy", 32'(bus.pulse_busy), 32'd0);
        chk("rst_start", 32'(bus.pulse_start), 32'd0);
        chk("rst_channel", 32'(bus.pulse_channel), 32'd0);
        chk("rst_wave", 32'(bus.pulse_wave_id), 32'd0);
        chk("rst_late_flag", 32'(bus.late_flag), 32'd0);
        chk("rst_late_count", 32'(bus.late_count), 32'd0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst_n = 1'b1;

        // Empty FIFO never pops
        bus.time_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("empty_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            chk("empty_busy", 32'(bus.pulse_busy), 32'd0);
            chk("empty_time", 32'(bus.time_now), 32'(tm));
        end

        // Frozen timebase, then clear with priority over run
        bus.time_run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze_time", 32'(bus.time_now), 32'(tm));
        end
        bus.time_run = 1'b1;
        bus.time_clr = 1'b1;
        tick();
        chk("clr_time", 32'(bus.time_now), 32'd0);
        bus.time_clr = 1'b0;

        // Start 10, duration 4
        push(8'd10, 4, 2, 5);
        run_batch(-1);

        // Late pulse detected at time 100
        while (tm != 8'd99) tick();
        push(8'd50, 1, 1, 3);
        run_batch(-1);

        // Three queued descriptors
        push(tm - 8'd5, 2, 3, 17);
        push(tm + 8'd4, 0, 6, 33);
        push(tm - 8'd30, 3, 7, 250);
        run_batch(-1);

        // Randomized batches
        for (int b = 0; b < 8; b++) begin
            int k;
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++)
                push(tm + TW'($urandom_range(0, 60)) - 8'd40, $urandom_range(0, 4),
                     $urandom_range(0, 7), $urandom_range(0, 255));
            run_batch((b % 3 == 0) ? 0 : -1);
        end

        // Standalone clear
        bus.late_clr = 1'b1;
        tick();
        bus.late_clr = 1'b0;
        lc = 0; lf = 0;
        chk("clr_flag", 32'(bus.late_flag), 32'd0);
        chk("clr_count", 32'(bus.late_count), 32'd0);

        // Wrap: start 3 pushed near 250 is in the future, not late
        while (tm != 8'd250) tick();
        push(8'd3, 2, 4, 200);
        run_batch(-1);

        // Late saturation, then clear coinciding with a late detection
        for (int i = 0; i < 260; i++) begin
            push(tm - 8'd20, 0, i % 8, i % 256);
            run_batch(-1);
        end
        chk("sat_count", 32'(bus.late_count), 32'd255);
        push(tm - 8'd20, 1, 5, 66);
        run_batch(0);
        chk("clr_with_late", 32'(bus.late_count), 32'd1);

        // Reset in the third PLAY cycle of an 8-cycle pulse
        push(tm - 8'd5, 8, 4, 9);
        push(8'd6, 3, 2, 77);
        #1;
        chk("mid_pop", 32'(bus.fifo_rd_en), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("mid_busy", 32'(bus.pulse_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        tm = '0; lc = 0; lf = 0;
        chk("mid_rst_busy", 32'(bus.pulse_busy), 32'd0);
        chk("mid_rst_channel", 32'(bus.pulse_channel), 32'd0);
        chk("mid_rst_wave", 32'(bus.pulse_wave_id), 32'd0);
        chk("mid_rst_time", 32'(bus.time_now), 32'd0);
        chk("mid_rst_late", 32'(bus.late_count), 32'd0);
        chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        chk("mid_rst_no_pop", 32'(wr_ptr - rd_ptr), 32'd1);
        rst_n = 1'b1;
        run_batch(-1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
